// File: rtl/router_pkg.sv
// Definitions shared by the router transmit and receive sides:
// packet header layout, address limits and the transmit FSM state type.
package router_pkg;

   localparam int MAX_LEN = 63;
   localparam int LEN_W   = 6;
   localparam int ADDR_W  = 2;

   localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      HEADER,
      PAYLOAD,
      PARITY
   } state_t;

   // The header carries the payload length in its upper bits and the port below it.
   function automatic logic [7:0] makeHeader(input logic [LEN_W-1:0]  len,
                                             input logic [ADDR_W-1:0] addr);
      return {len, addr};
   endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload store for one outgoing packet: a single write port filled
// during loading and an asynchronous read port used while transmitting.
module router_tx_buf #(
   parameter int DEPTH = router_pkg::MAX_LEN,
   parameter int AW    = router_pkg::LEN_W
) (
   input  logic          clock,
   input  logic          i_wrEn,
   input  logic [AW-1:0] i_wrAddr,
   input  logic [7:0]    i_wrData,
   input  logic [AW-1:0] i_rdAddr,
   output logic [7:0]    o_rdData
);

   logic [7:0] r_mem [DEPTH];

   // Contents are never cleared; every byte is rewritten before it is read.
   always_ff @(posedge clock) begin
      if (i_wrEn) begin
         r_mem[i_wrAddr] <= i_wrData;
      end
   end

   assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers a payload, then sends header, payload and a
// parity byte to the router, holding each byte while the router is busy.
module router_pkt_tx #(
   parameter int MAX_LEN = router_pkg::MAX_LEN
) (
   input  logic                          clock,
   input  logic                          resetn,
   input  logic                          start,
   input  logic [router_pkg::ADDR_W-1:0] dest_addr,
   input  logic [router_pkg::LEN_W-1:0]  payload_len,
   input  logic                          corrupt_parity,
   input  logic [7:0]                    pl_data,
   input  logic                          pl_valid,
   output logic                          pl_ready,
   input  logic                          busy,
   output logic [7:0]                    data_out,
   output logic                          pkt_valid,
   output logic                          tx_active,
   output logic                          done
);

   import router_pkg::*;

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [LEN_W-1:0]  r_len;
   logic              r_corrupt;
   logic [7:0]        r_parity;
   logic [LEN_W-1:0]  r_cnt;
   logic [LEN_W-1:0]  r_idx;
   logic [7:0]        r_dataOut;
   logic              r_pktValid;
   logic              r_plReady;
   logic              r_txActive;
   logic              r_done;

   logic              w_wrEn;
   logic [LEN_W-1:0]  w_rdAddr;
   logic [7:0]        w_rdData;
   logic [7:0]        w_header;

   assign w_wrEn   = (r_state == LOAD) && pl_valid;
   assign w_header = makeHeader(r_len, r_addr);

   // Read one byte ahead so the next payload byte can be registered onto the bus.
   always_comb begin
      w_rdAddr = '0;
      if (r_state == PAYLOAD) begin
         w_rdAddr = r_idx + 6'd1;
      end
   end

   router_tx_buf #(
      .DEPTH (MAX_LEN),
      .AW    (LEN_W)
   ) u_buf (
      .clock    (clock),
      .i_wrEn   (w_wrEn),
      .i_wrAddr (r_cnt),
      .i_wrData (pl_data),
      .i_rdAddr (w_rdAddr),
      .o_rdData (w_rdData)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state    <= IDLE;
         r_addr     <= '0;
         r_len      <= '0;
         r_corrupt  <= 1'b0;
         r_parity   <= '0;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_dataOut  <= 8'h00;
         r_pktValid <= 1'b0;
         r_plReady  <= 1'b0;
         r_txActive <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start && (payload_len != '0) && (dest_addr != ADDR_INVALID)) begin
                  r_addr     <= dest_addr;
                  r_len      <= payload_len;
                  r_corrupt  <= corrupt_parity;
                  r_parity   <= makeHeader(payload_len, dest_addr);
                  r_cnt      <= '0;
                  r_idx      <= '0;
                  r_plReady  <= 1'b1;
                  r_txActive <= 1'b1;
                  r_state    <= LOAD;
               end
            end
            LOAD: begin
               if (pl_valid) begin
                  r_parity <= r_parity ^ pl_data;
                  r_cnt    <= r_cnt + 6'd1;
                  if (r_cnt == (r_len - 6'd1)) begin
                     r_plReady  <= 1'b0;
                     r_dataOut  <= w_header;
                     r_pktValid <= 1'b1;
                     r_state    <= HEADER;
                  end
               end
            end
            HEADER: begin
               if (!busy) begin
                  r_idx     <= '0;
                  r_dataOut <= w_rdData;
                  r_state   <= PAYLOAD;
               end
            end
            PAYLOAD: begin
               if (!busy) begin
                  if (r_idx == (r_len - 6'd1)) begin
                     r_dataOut  <= r_parity ^ {8{r_corrupt}};
                     r_pktValid <= 1'b0;
                     r_state    <= PARITY;
                  end else begin
                     r_idx     <= r_idx + 6'd1;
                     r_dataOut <= w_rdData;
                  end
               end
            end
            PARITY: begin
               if (!busy) begin
                  r_dataOut  <= 8'h00;
                  r_txActive <= 1'b0;
                  r_done     <= 1'b1;
                  r_state    <= IDLE;
               end
            end
            default: begin
               r_dataOut  <= 8'h00;
               r_pktValid <= 1'b0;
               r_plReady  <= 1'b0;
               r_txActive <= 1'b0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

   assign data_out  = r_dataOut;
   assign pkt_valid = r_pktValid;
   assign pl_ready  = r_plReady;
   assign tx_active = r_txActive;
   assign done      = r_done;

endmodule

// File: doc/router_pkt_tx.md
ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 Parameter: MAX_LEN, 63, largest accepted payload length in bytes; sizes the payload buffer.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to send one packet; sampled only in IDLE.
REQ-005 dest_addr  input  2  destination port 0..2; 2'b11 invalid.
REQ-006 payload_len  input  6  payload byte count, 1..MAX_LEN; 0 invalid.
REQ-007 corrupt_parity  input  1  when high at start, the parity byte sent is bitwise-inverted.
REQ-008 pl_data  input  8  payload byte.
REQ-009 pl_valid  input  1  pl_data valid.
REQ-010 pl_ready  output  1  block accepts a payload byte this cycle.
REQ-011 busy  input  1  router back-pressure; high = hold current byte.
REQ-012 data_out  output  8  byte to router.
REQ-013 pkt_valid  output  1  high on header and payload bytes, low on parity byte and when idle.
REQ-014 tx_active  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse when the parity byte is accepted.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, HEADER, PAYLOAD, PARITY.
REQ-017 IDLE: start=1 with payload_len!=0 and dest_addr!=2'b11 SHALL latch addr, len, corrupt_parity, set parity register to header, go to LOAD; invalid request SHALL be ignored (stay IDLE).
REQ-018 start in any state other than IDLE SHALL be ignored.
REQ-019 Header byte SHALL be {payload_len, dest_addr}.
REQ-020 LOAD: pl_ready=1; each cycle with pl_valid=1 SHALL write pl_data to buffer[cnt], XOR it into parity, increment cnt; on the write of byte len-1 go to HEADER; pl_ready=0 in all other states.
REQ-021 HEADER: data_out=header, pkt_valid=1; at an edge with busy=0 go to PAYLOAD, idx=0.
REQ-022 PAYLOAD: data_out=buffer[idx], pkt_valid=1; at an edge with busy=0 increment idx; after byte len-1 accepted go to PARITY.
REQ-023 PARITY: data_out=parity (or ~parity if corrupt latched), pkt_valid=0; at an edge with busy=0 go to IDLE and pulse done for exactly the following cycle.
REQ-024 While busy=1 in HEADER/PAYLOAD/PARITY, data_out, pkt_valid and state SHALL hold unchanged; busy SHALL be ignored in IDLE and LOAD.
REQ-025 data_out and pkt_valid SHALL be registered; no combinational path from busy or pl_valid to data_out/pkt_valid.
REQ-026 With busy=0 throughout, the router-side transfer SHALL occupy exactly len+2 consecutive cycles (header, len payload, parity), pkt_valid high for len+1 of them.
REQ-027 IDLE and LOAD: data_out=8'h00, pkt_valid=0.
REQ-028 cnt/idx SHALL be 6 bits; no wrap occurs because len<=63.

Reset
REQ-029 resetn=0 SHALL asynchronously force IDLE, data_out=8'h00, pkt_valid=0, pl_ready=0, tx_active=0, done=0, cnt=idx=0, parity=0; buffer contents need not be cleared.
REQ-030 Reset mid-packet SHALL abandon the packet; first packet after release starts cleanly from start.

Structure
REQ-031 Shared package router_pkg SHALL hold the FSM state type, MAX_LEN, ADDR_INVALID=2'b11 and header field widths (len 6, addr 2), shared with the router receive side.
REQ-032 Payload storage SHALL be one sub-module router_tx_buf (MAX_LEN x 8, one write port, one async read port); FSM, counters, parity in router_pkt_tx.

Verification
REQ-033 addr=2'b10, len=1, pl_data=8'hA5, busy=0 -> bus sequence 8'h06 (pkt_valid=1), 8'hA5 (1), 8'hA3 (0); done pulses once.
REQ-034 Same packet with corrupt_parity=1 -> parity byte 8'h5C, all else identical.
REQ-035 len=8 random payload, busy=1 for 3 cycles on payload byte 4 -> that byte held 4 cycles, total 13 bus cycles, parity equals XOR of header and payload.
REQ-036 start with len=0, then with addr=2'b11 -> stays IDLE, tx_active=0, pl_ready=0.
REQ-037 pl_valid low for 5 cycles during LOAD of len=4 -> no bus activity until 4th byte written; transmitted bytes match in order.
REQ-038 resetn pulled low during PAYLOAD of len=8 -> pkt_valid=0, data_out=0 immediately; following len=2 packet transmits correctly.
